// File: rtl/hazard_forward_ctrl_if.sv
// Decode-side hazard request signals and the EX-stage control responses.
// The master side is the pipeline (it drives the ID and EX tags); the slave side is the hazard controller.
interface hazard_forward_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [3:0]       id_rn;
    logic [3:0]       id_rm;
    logic             id_uses_rn;
    logic             id_uses_rm;
    logic [3:0]       id_dest;
    logic             id_wb_en;
    logic             id_mem_read;
    logic             ex_branch_taken;
    logic [1:0]       src1_sel;
    logic [1:0]       src2_sel;
    logic             stall;
    logic             flush;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_cycles;

    modport master (
        output id_valid, id_rn, id_rm, id_uses_rn, id_uses_rm,
               id_dest, id_wb_en, id_mem_read, ex_branch_taken,
        input  src1_sel, src2_sel, stall, flush, stall_cycles, flush_cycles
    );

    modport slave (
        input  id_valid, id_rn, id_rm, id_uses_rn, id_uses_rm,
               id_dest, id_wb_en, id_mem_read, ex_branch_taken,
        output src1_sel, src2_sel, stall, flush, stall_cycles, flush_cycles
    );
endinterface

// File: rtl/hazard_forward_ctrl.sv
// Load-use stall, branch flush and EX operand forwarding for a 5-stage pipeline; controls are combinational, counters registered.
// HAZARD_FORWARD_EN enables MEM/WB forwarding; without it any in-flight producer stalls ID until it leaves WB.
module hazard_forward_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    hazard_forward_ctrl_if.slave  hz
);
    typedef struct packed {
        logic       valid;
        logic [3:0] dest;
        logic       wb_en;
        logic       mem_read;
    } tag_t;

    typedef struct packed {
        tag_t       tag;
        logic [3:0] rn;
        logic [3:0] rm;
        logic       uses_rn;
        logic       uses_rm;
    } ex_slot_t;

    ex_slot_t         ex_q;
    ex_slot_t         ex_d;
    tag_t             mem_q;
    tag_t             wb_q;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             stall;
    logic             flush;

    function automatic logic raw(tag_t s, logic [3:0] rn, logic [3:0] rm,
                                 logic uses_rn, logic uses_rm);
        return s.valid & s.wb_en &
               ((uses_rn & (rn == s.dest)) | (uses_rm & (rm == s.dest)));
    endfunction

    assign flush = hz.ex_branch_taken;

`ifdef HAZARD_FORWARD_EN
    // Non-load producers are covered by forwarding; only a load still in EX must wait one cycle.
    assign stall = hz.id_valid & ~flush & ex_q.tag.mem_read &
                   raw(ex_q.tag, hz.id_rn, hz.id_rm, hz.id_uses_rn, hz.id_uses_rm);

    // A load in MEM has no data yet, so it is skipped and the WB value cannot be older than needed.
    function automatic logic [1:0] fwd_sel(logic uses, logic [3:0] r, tag_t mem, tag_t wb);
        if (uses & mem.valid & mem.wb_en & ~mem.mem_read & (mem.dest == r))
            return 2'd1;
        if (uses & wb.valid & wb.wb_en & (wb.dest == r))
            return 2'd2;
        return 2'd0;
    endfunction

    assign hz.src1_sel = ex_q.tag.valid ? fwd_sel(ex_q.uses_rn, ex_q.rn, mem_q, wb_q) : 2'd0;
    assign hz.src2_sel = ex_q.tag.valid ? fwd_sel(ex_q.uses_rm, ex_q.rm, mem_q, wb_q) : 2'd0;

    logic unused_tags;
    assign unused_tags = wb_q.mem_read;
`else
    assign stall = hz.id_valid & ~flush &
                   (raw(ex_q.tag, hz.id_rn, hz.id_rm, hz.id_uses_rn, hz.id_uses_rm) |
                    raw(mem_q,    hz.id_rn, hz.id_rm, hz.id_uses_rn, hz.id_uses_rm) |
                    raw(wb_q,     hz.id_rn, hz.id_rm, hz.id_uses_rn, hz.id_uses_rm));

    assign hz.src1_sel = 2'd0;
    assign hz.src2_sel = 2'd0;

    logic unused_tags;
    assign unused_tags = ^{ex_q.rn, ex_q.rm, ex_q.uses_rn, ex_q.uses_rm,
                           ex_q.tag.mem_read, mem_q.mem_read, wb_q.mem_read};
`endif

    assign hz.stall        = stall;
    assign hz.flush        = flush;
    assign hz.stall_cycles = stall_cnt;
    assign hz.flush_cycles = flush_cnt;

    always_comb begin
        ex_d = '0;
        if (!(stall || flush)) begin
            ex_d.tag.valid    = hz.id_valid;
            ex_d.tag.dest     = hz.id_dest;
            ex_d.tag.wb_en    = hz.id_wb_en;
            ex_d.tag.mem_read = hz.id_mem_read;
            ex_d.rn           = hz.id_rn;
            ex_d.rm           = hz.id_rm;
            ex_d.uses_rn      = hz.id_uses_rn;
            ex_d.uses_rm      = hz.id_uses_rm;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q      <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q.tag;
            wb_q  <= mem_q;
            if (stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end
endmodule

// File: doc/hazard_forward_ctrl.md
Name: hazard_forward_ctrl

Overview:
- Hazard and forwarding controller for the 5-stage ARM pipeline (IF/ID/EX/MEM/WB).
- Keeps a shadow pipeline of destination, write-back and memory-read tags for the EX, MEM and WB slots.
- Drives the execution stage's operand-source selects (0 = register file value, 1 = MEM-stage result, 2 = WB-stage result).
- Raises the load-use stall and the branch flush.
- Counts stall and flush cycles for performance monitoring.

Parameters:
- CNT_W, 16, width of the saturating stall and flush cycle counters.

Ports:
- clk  in  1  pipeline clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rn  in  4  first source register of the ID instruction
- id_rm  in  4  second source register of the ID instruction
- id_uses_rn  in  1  ID instruction reads Rn
- id_uses_rm  in  1  ID instruction reads Rm (register operand or store data)
- id_dest  in  4  destination register of the ID instruction
- id_wb_en  in  1  ID instruction writes the register file
- id_mem_read  in  1  ID instruction is a load
- ex_branch_taken  in  1  instruction in EX is a taken branch
- src1_sel  out  2  EX Rn operand select
- src2_sel  out  2  EX Rm operand select
- stall  out  1  freeze PC and IF/ID, insert bubble into ID/EX
- flush  out  1  squash IF/ID and ID/EX contents
- stall_cycles  out  CNT_W  saturating count of stall cycles
- flush_cycles  out  CNT_W  saturating count of flush cycles

Behaviour:
- Shadow slots: EX, MEM and WB. Each slot holds valid, dest, wb_en and mem_read. The EX slot also holds rn, rm, uses_rn and uses_rm.
- Reset (rst=1 at an edge): all slot valid bits 0, all fields 0, both counters 0. Outputs then read src1_sel=0, src2_sel=0, stall=0, flush=0.
- Per cycle: WB <= MEM and MEM <= EX, always.
- EX update:
  - EX <= ID fields, with valid = id_valid.
  - If stall or flush is high, EX instead receives a bubble (valid=0).
- RAW match between a slot S and the ID instruction: S.valid, S.wb_en, and (id_uses_rn & id_rn==S.dest or id_uses_rm & id_rm==S.dest).
- stall (combinational):
  - id_valid & RAW match against EX & EX.mem_read & !flush.
  - Exactly one bubble per load-use: next cycle the load sits in MEM and no longer matches the EX rule.
- flush (combinational) = ex_branch_taken.
  - Flush has priority over stall: when both conditions hold, stall=0.
  - Branch in EX with a dependent load ahead: the dependent instruction is squashed, no stall.
- Forward selects (combinational, from the EX slot tags):
  - src1_sel = 1 if EX.uses_rn & MEM.valid & MEM.wb_en & !MEM.mem_read & MEM.dest==EX.rn.
  - Otherwise 2 if EX.uses_rn & WB.valid & WB.wb_en & WB.dest==EX.rn.
  - Otherwise 0.
  - src2_sel: same rule using EX.rm and EX.uses_rm.
  - MEM has priority over WB when both match (youngest value wins).
  - If EX.valid=0, both selects are 0.
- R15 is treated like any other register. No special case.
- Counters:
  - stall_cycles increments on every cycle with stall=1.
  - flush_cycles increments on every cycle with flush=1.
  - Both saturate at all-ones; no wrap.
- Reset mid-operation: all in-flight tags are discarded. The first cycle after reset produces no stall, flush or forward.

Optional Feature:
- Macro: HAZARD_FORWARD_EN.
- Defined: behaviour as above.
- Undefined:
  - src1_sel and src2_sel are constant 0.
  - stall = id_valid & !flush & RAW match against any of EX, MEM or WB, regardless of mem_read.
  - The pipeline waits until the producer has left WB.
  - Counters behave unchanged.

Test Plan:
- Reset then ADD R1 followed by SUB R2,R1,R3 (uses_rn) -> SUB in EX with src1_sel=1, src2_sel=0; stall never 1.
- ADD R1; MOV R5; SUB R2,R3,R1 (uses_rm) -> SUB in EX with src2_sel=2.
- ADD R1 then ADD R1 then ORR R4,R1,R1 -> src1_sel=1 and src2_sel=1 (MEM wins over WB).
- LDR R4 then ADD R6,R4,R0 -> stall=1 for exactly 1 cycle; stall_cycles=1; ADD then reaches EX with src1_sel=2.
- LDR R4, dependent ADD in ID, ex_branch_taken=1 in the same cycle -> flush=1, stall=0; next EX slot is a bubble (selects 0); flush_cycles=1.
- Hold a load-use pattern 70000 cycles with CNT_W=16 -> stall_cycles saturates at 65535. Assert rst -> both counters read 0 the next cycle.
